// File: rtl/cva6_spi_master_tx.sv
// SPI master transmit shifter: pulls 32-bit words from the TX FIFO and shifts them out MSB first on the clock generator's falling-edge strobe.
// Optional quad-lane output is enabled by defining SPI_MASTER_TX_QUAD_EN.
module cva6_spi_master_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tx_edge,
  input  logic        en_quad_in,
  input  logic [15:0] counter_in,
  input  logic        counter_in_upd,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        clk_en_o,
  output logic        tx_done,
  output logic        sdo0,
  output logic        sdo1,
  output logic        sdo2,
  output logic        sdo3
);

  typedef enum logic [1:0] {IDLE, TRANSMIT, WAIT_DATA} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_target;
  logic [15:0] r_counter, w_counter_nxt;
  logic [31:0] r_data_int, w_data_nxt;
  logic        r_quad, w_quad_nxt;
  logic        r_clk_en, w_clk_en_nxt;
  logic        r_tx_done, w_tx_done_nxt;

  logic [16:0] w_step;
  logic [16:0] w_next;
  logic        w_end;
  logic        w_word_bnd;
  logic [31:0] w_shifted;
  logic        w_quad_sel;

`ifdef SPI_MASTER_TX_QUAD_EN
  assign w_quad_sel = en_quad_in;
`else
  logic w_unused_quad;
  assign w_unused_quad = en_quad_in;
  assign w_quad_sel    = 1'b0;
`endif

  // 17-bit compare so a counter near 16'hFFFF cannot wrap past the target
  assign w_step     = r_quad ? 17'd4 : 17'd1;
  assign w_next     = {1'b0, r_counter} + w_step;
  assign w_end      = (w_next >= {1'b0, r_target});
  assign w_word_bnd = (w_next[4:0] == 5'd0);
  assign w_shifted  = r_quad ? {r_data_int[27:0], 4'h0} : {r_data_int[30:0], 1'b0};

  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_data_nxt    = r_data_int;
    w_quad_nxt    = r_quad;
    w_clk_en_nxt  = r_clk_en;
    w_tx_done_nxt = 1'b0;
    data_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        data_ready = en && (r_target != 16'd0);
        if (en && (r_target != 16'd0) && data_valid) begin
          w_data_nxt    = data;
          w_quad_nxt    = w_quad_sel;
          w_counter_nxt = 16'd0;
          w_clk_en_nxt  = 1'b1;
          w_state_nxt   = TRANSMIT;
        end else if (en && (r_target == 16'd0)) begin
          w_tx_done_nxt = 1'b1;
        end
      end
      TRANSMIT: begin
        if (tx_edge) begin
          w_counter_nxt = w_next[15:0];
          if (w_end) begin
            w_data_nxt    = w_shifted;
            w_clk_en_nxt  = 1'b0;
            w_tx_done_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else if (w_word_bnd) begin
            // Word boundary: take the next word now so SCK keeps running without a gap
            data_ready = 1'b1;
            if (data_valid) begin
              w_data_nxt = data;
            end else begin
              w_data_nxt   = w_shifted;
              w_clk_en_nxt = 1'b0;
              w_state_nxt  = WAIT_DATA;
            end
          end else begin
            w_data_nxt = w_shifted;
          end
        end
      end
      WAIT_DATA: begin
        data_ready = 1'b1;
        if (data_valid) begin
          w_data_nxt   = data;
          w_clk_en_nxt = 1'b1;
          w_state_nxt  = TRANSMIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_target   <= 16'd0;
      r_counter  <= 16'd0;
      r_data_int <= 32'd0;
      r_quad     <= 1'b0;
      r_clk_en   <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_counter  <= w_counter_nxt;
      r_data_int <= w_data_nxt;
      r_quad     <= w_quad_nxt;
      r_clk_en   <= w_clk_en_nxt;
      r_tx_done  <= w_tx_done_nxt;
      if (counter_in_upd) begin
        r_target <= counter_in;
      end
    end
  end

  assign clk_en_o = r_clk_en;
  assign tx_done  = r_tx_done;

`ifdef SPI_MASTER_TX_QUAD_EN
  assign sdo0 = r_quad ? r_data_int[28] : r_data_int[31];
  assign sdo1 = r_quad & r_data_int[29];
  assign sdo2 = r_quad & r_data_int[30];
  assign sdo3 = r_quad & r_data_int[31];
`else
  assign sdo0 = r_data_int[31];
  assign sdo1 = 1'b0;
  assign sdo2 = 1'b0;
  assign sdo3 = 1'b0;
`endif

endmodule

// File: tb/tb_cva6_spi_master_tx.sv
// Directed bench for cva6_spi_master_tx: single-lane transfers, word boundaries, zero length, reset and (with SPI_MASTER_TX_QUAD_EN) quad mode.
module tb_cva6_spi_master_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tx_edge;
  logic        en_quad_in;
  logic [15:0] counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        clk_en_o;
  logic        tx_done;
  logic        sdo0, sdo1, sdo2, sdo3;

  int n_chk  = 0;
  int n_pass = 0;
  logic r_start_rdy;

  cva6_spi_master_tx dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .tx_edge        (tx_edge),
    .en_quad_in     (en_quad_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .clk_en_o       (clk_en_o),
    .tx_done        (tx_done),
    .sdo0           (sdo0),
    .sdo1           (sdo1),
    .sdo2           (sdo2),
    .sdo3           (sdo3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic set_target(input logic [15:0] t);
    counter_in     = t;
    counter_in_upd = 1'b1;
    gap();
    counter_in_upd = 1'b0;
  endtask

  task automatic start_word(input logic [31:0] w, input logic q);
    data       = w;
    data_valid = 1'b1;
    en         = 1'b1;
    en_quad_in = q;
    @(negedge clk);
    r_start_rdy = data_ready;
    gap();
    data_valid = 1'b0;
    en         = 1'b0;
    en_quad_in = 1'b0;
  endtask

  task automatic edge_(output logic rdy);
    tx_edge = 1'b1;
    @(negedge clk);
    rdy = data_ready;
    gap();
    tx_edge = 1'b0;
  endtask

  task automatic xfer8(input string tag, input logic [31:0] w);
    int   rdy_cnt;
    logic r;
    set_target(16'd8);
    start_word(w, 1'b0);
    rdy_cnt = int'(r_start_rdy);
    chk($sformatf("%s_clken_start", tag), {31'd0, clk_en_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_sdo_bit%0d", tag, i), {31'd0, sdo0}, {31'd0, w[31-i]});
      edge_(r);
      rdy_cnt += int'(r);
      if (i < 7) gap();
    end
    chk($sformatf("%s_done", tag), {31'd0, tx_done}, 32'd1);
    chk($sformatf("%s_clken_end", tag), {31'd0, clk_en_o}, 32'd0);
    chk($sformatf("%s_ready_pulses", tag), rdy_cnt, 32'd1);
    gap();
    chk($sformatf("%s_done_clear", tag), {31'd0, tx_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic r;
    logic ok;
    logic [31:0] w;
    rst = 1'b1; en = 1'b1; tx_edge = 1'b0; en_quad_in = 1'b0;
    counter_in = 16'd0; counter_in_upd = 1'b0; data = 32'd0; data_valid = 1'b1;
    gap(); gap();
    @(negedge clk);
    chk("rst_ready", {31'd0, data_ready}, 32'd0);
    chk("rst_clken", {31'd0, clk_en_o}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd0);
    en = 1'b0; data_valid = 1'b0;
    gap();
    rst = 1'b0;
    gap();

    // tx_edge in IDLE has no effect
    edge_(r);
    chk("idle_edge_clken", {31'd0, clk_en_o}, 32'd0);
    chk("idle_edge_done", {31'd0, tx_done}, 32'd0);

    xfer8("single8", 32'hA5000000);

    // 40 bits, second word present at the boundary edge
    set_target(16'd40);
    w = 32'hDEADBEEF;
    start_word(w, 1'b0);
    ok = clk_en_o;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("w40_sdo_bit%0d", i), {31'd0, sdo0}, {31'd0, w[31-i]});
      if (i == 31) begin data = 32'hFF000000; data_valid = 1'b1; end
      edge_(r);
      data_valid = 1'b0;
      if (i == 31) chk("w40_ready_at_boundary", {31'd0, r}, 32'd1);
      ok = ok & clk_en_o;
      gap();
      ok = ok & clk_en_o;
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w40_second_bit%0d", i), {31'd0, sdo0}, 32'd1);
      edge_(r);
      if (i < 7) begin ok = ok & clk_en_o; gap(); ok = ok & clk_en_o; end
    end
    chk("w40_done", {31'd0, tx_done}, 32'd1);
    chk("w40_clken_never_dropped", {31'd0, ok}, 32'd1);
    gap();

    // 40 bits, second word late; a stray tx_edge while waiting must not count
    set_target(16'd40);
    w = 32'h0F0F0F0F;
    start_word(w, 1'b0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("late_sdo_bit%0d", i), {31'd0, sdo0}, {31'd0, w[31-i]});
      edge_(r);
      if (i < 31) gap();
    end
    chk("late_clken_drop", {31'd0, clk_en_o}, 32'd0);
    chk("late_wait_ready", {31'd0, data_ready}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin edge_(r); ok = ok & ~clk_en_o; end
      else begin gap(); ok = ok & ~clk_en_o; end
    end
    chk("late_clken_low_while_waiting", {31'd0, ok}, 32'd1);
    chk("late_no_done_while_waiting", {31'd0, tx_done}, 32'd0);
    w = 32'hAA000000;
    data = w; data_valid = 1'b1;
    gap();
    data_valid = 1'b0;
    chk("late_clken_resume", {31'd0, clk_en_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("late_second_bit%0d", i), {31'd0, sdo0}, {31'd0, w[31-i]});
      edge_(r);
      if (i < 7) gap();
    end
    chk("late_done", {31'd0, tx_done}, 32'd1);
    chk("late_clken_end", {31'd0, clk_en_o}, 32'd0);
    gap();

    // Zero-length request
    set_target(16'd0);
    data = 32'h12345678; data_valid = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("zero_ready", {31'd0, data_ready}, 32'd0);
    gap();
    en = 1'b0; data_valid = 1'b0;
    chk("zero_done", {31'd0, tx_done}, 32'd1);
    chk("zero_clken", {31'd0, clk_en_o}, 32'd0);
    gap();
    chk("zero_done_clear", {31'd0, tx_done}, 32'd0);

    // Target lowered below the running counter ends on the next edge
    set_target(16'd32);
    start_word(32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin edge_(r); gap(); end
    set_target(16'd2);
    chk("upd_not_done_yet", {31'd0, tx_done}, 32'd0);
    edge_(r);
    chk("upd_done", {31'd0, tx_done}, 32'd1);
    chk("upd_clken", {31'd0, clk_en_o}, 32'd0);
    gap();

    // Reset after 5 of 8 bits
    set_target(16'd8);
    start_word(32'hC3000000, 1'b0);
    for (int i = 0; i < 5; i++) begin edge_(r); gap(); end
    rst = 1'b1;
    gap();
    rst = 1'b0;
    chk("mrst_clken", {31'd0, clk_en_o}, 32'd0);
    chk("mrst_done", {31'd0, tx_done}, 32'd0);
    chk("mrst_sdo", {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd0);
    chk("mrst_target", {16'd0, dut.r_target}, 32'd0);
    chk("mrst_counter", {16'd0, dut.r_counter}, 32'd0);
    chk("mrst_data", dut.r_data_int, 32'd0);
    gap();
    chk("mrst_no_done", {31'd0, tx_done}, 32'd0);
    xfer8("after_rst", 32'h5A000000);

`ifdef SPI_MASTER_TX_QUAD_EN
    for (int pass = 0; pass < 2; pass++) begin
      set_target(pass == 0 ? 16'd16 : 16'd14);
      start_word(32'h12340000, 1'b1);
      chk($sformatf("quad%0d_nib0", pass), {28'd0, sdo3, sdo2, sdo1, sdo0}, 32'd1);
      for (int i = 0; i < 4; i++) begin
        edge_(r);
        if (i < 3) begin
          chk($sformatf("quad%0d_nib%0d", pass, i + 1), {28'd0, sdo3, sdo2, sdo1, sdo0}, i + 2);
          chk($sformatf("quad%0d_notdone%0d", pass, i), {31'd0, tx_done}, 32'd0);
          gap();
        end
      end
      chk($sformatf("quad%0d_done", pass), {31'd0, tx_done}, 32'd1);
      gap();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cva6_spi_master_tx.md
# cva6_spi_master_tx

Transmit shifter of the SPI master. It sits directly downstream of the SPI clock generator and consumes that block's falling-edge strobe to shift data onto the SDO line(s). It pulls 32-bit words from the TX FIFO with a valid/ready handshake and drives the clock generator's enable, so SCK runs only while bits remain and data is available. The data path is standard single-lane, with an optional quad-lane mode.

## Interface
- No parameters. Word width is fixed at 32 and the bit counter at 16.
- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  start request, sampled in IDLE only
- `tx_edge`  in  1  one-cycle strobe from the clock generator's `spi_fall`
- `en_quad_in`  in  1  quad mode select, sampled when a word is loaded in IDLE
- `counter_in`  in  16  transfer length in bits
- `counter_in_upd`  in  1  loads `counter_in` into the target register in any state
- `data`  in  32  TX word, MSB first
- `data_valid`  in  1  TX word available
- `data_ready`  out  1  combinational; a word is accepted when `data_valid && data_ready`
- `clk_en_o`  out  1  registered; drives the clock generator's `en`
- `tx_done`  out  1  registered one-cycle pulse at end of transfer
- `sdo0`..`sdo3`  out  1 each  serial outputs

## Operation
- **Registers**
  - `target[15:0]`
  - `counter[15:0]`
  - `data_int[31:0]`
  - `quad`
  - state: IDLE, TRANSMIT, WAIT_DATA
- **Outputs**
  - Single mode: `sdo0 = data_int[31]`; `sdo1..3 = 0`.
  - Quad mode: `{sdo3,sdo2,sdo1,sdo0} = data_int[31:28]`.
- **Step**
  - Step is 1 bit in single mode, 4 bits in quad mode.
  - Each `tx_edge` in TRANSMIT adds the step to `counter` and shifts `data_int` left by the step, zero-filling.
- **IDLE**
  - `data_ready = en && target != 0`.
  - On accept: load `data_int`, latch `quad`, clear `counter`, set `clk_en_o = 1`, go to TRANSMIT.
  - `en` with `target == 0`: no word is consumed. `tx_done` pulses next cycle and the block stays in IDLE.
- **TRANSMIT**
  - Each `tx_edge` computes `next = counter + step`.
  - If `next >= target`: end of transfer. Set `clk_en_o = 0` and go to IDLE.
  - Else if `next[4:0] == 0`: word boundary. `data_ready = 1` in this cycle.
    - If a word is accepted, load `data_int` and stay in TRANSMIT.
    - If not, set `clk_en_o = 0` and go to WAIT_DATA.
  - Else: shift only.
- **WAIT_DATA**
  - `data_ready = 1`.
  - On accept: load `data_int`, set `clk_en_o = 1`, go to TRANSMIT.
- **Target width rule**
  - In quad mode, a target that is not a multiple of 4 ends at the first multiple above it (the `>=` compare).
  - Comparison is 17 bits wide, so no wrap-around occurs.
- **Boundary cases**
  - `counter_in_upd` mid-transfer takes effect immediately. If the new target is at or below `counter`, the transfer ends on the next `tx_edge`.
  - Deasserting `en` mid-transfer is ignored; the transfer completes.
  - `tx_edge` outside TRANSMIT is ignored.
  - `rst` mid-transfer: next cycle the block is in IDLE with all registers and outputs zero. No `tx_done` is issued.

## Timing
- **Reset values**
  - `clk_en_o = 0`, `tx_done = 0`, `sdo0..3 = 0`
  - `data_int`, `counter`, `target` and `quad` all 0; state IDLE
  - `data_ready = 0` (the target is 0)
- **Start**
  - Accept at cycle N. `sdo` shows the word MSB(s) and `clk_en_o = 1` from N+1.
  - The first SCK rise therefore samples valid data (mode 0).
- **Shift**
  - `tx_edge` at cycle M gives the new `sdo` at M+1, while SCK is low.
- **End**
  - Last `tx_edge` at M gives `tx_done = 1` and `clk_en_o = 0` at M+1. `tx_done` clears at M+2.
  - IDLE at M+1, so a new transfer may be accepted at M+1.
- **Word boundary**
  - A word present at the boundary edge is accepted in the same cycle, so SCK runs with no gap.
  - A late word accepted at cycle K gives `clk_en_o = 1` at K+1.

## Configuration
- `SPI_MASTER_TX_QUAD_EN` defined: quad mode is available; `en_quad_in` is latched into `quad`.
- Not defined: `quad` is tied to 0, `en_quad_in` is ignored, and `sdo1..3` are constant 0.

## Test plan
- **8-bit single:** `target = 8`, `data = 0xA5000000`, `en` set.
  - One `data_ready` pulse.
  - `sdo0` = 1,0,1,0,0,1,0,1 across 8 `tx_edge`s.
  - `tx_done` for one cycle after the 8th edge, with `clk_en_o` low at the same cycle.
- **40-bit, second word ready:** second word `0xFF000000` valid at the 32nd edge.
  - `data_ready` asserted at that edge; `clk_en_o` never drops.
  - `sdo0` = 1 for the next 8 edges, then `tx_done`.
- **40-bit, late second word:** no word at the 32nd edge.
  - State goes to WAIT_DATA and `clk_en_o = 0` next cycle.
  - Word arrives 10 cycles later: `clk_en_o = 1` the cycle after the accept; 8 more bits go out.
- **Quad (macro defined):** `target = 16`, `data = 0x12340000`, quad selected.
  - Nibbles 1, 2, 3, 4 appear on `sdo3..0`.
  - `tx_done` after the 4th edge.
  - Repeat with `target = 14`: same 4 edges.
- **Zero length:** `target = 0`, `en` pulsed.
  - `data_ready` stays 0 and `tx_done` pulses once.
  - `clk_en_o` stays 0.
- **Reset mid-transfer:** `rst` asserted after 5 of 8 bits.
  - All outputs and registers are 0 next cycle; no `tx_done`.
  - A new 8-bit transfer afterwards completes normally.
